// File: rtl/mem_commit_if.sv
// Execute-bundle and data-memory port bundles for mem_commit.
// The master modport is the side that drives the request.
interface mem_commit_if;
    logic        exec_valid;
    logic        exec_ready;
    logic [31:0] data;
    logic        mem_write_enabled;
    logic [31:0] mem_write_dest;
    logic        reg_write_enabled;
    logic [5:0]  reg_write_dest;
    logic        is_jump_enabled;
    logic [31:0] jump_dest;

    modport master (
        output exec_valid, data, mem_write_enabled, mem_write_dest,
               reg_write_enabled, reg_write_dest, is_jump_enabled, jump_dest,
        input  exec_ready
    );
    modport slave (
        input  exec_valid, data, mem_write_enabled, mem_write_dest,
               reg_write_enabled, reg_write_dest, is_jump_enabled, jump_dest,
        output exec_ready
    );
endinterface

interface mem_commit_dmem_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;

    modport master (output mem_req, mem_addr, mem_wdata, input mem_ack);
    modport slave  (input mem_req, mem_addr, mem_wdata, output mem_ack);
endinterface

// File: rtl/mem_commit.sv
// Commit stage: performs an optional store over a req/ack port, then retires
// the bundle with registered register-file write and PC redirect strobes.
module mem_commit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rstn,
    mem_commit_if.slave             ex,
    mem_commit_dmem_if.master       dm,
    output logic                    rf_we,
    output logic [5:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc,
    output logic                    commit,
    output logic [31:0]             retired_count,
    output logic                    misalign_err,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, COMMIT} state_e;

    typedef struct packed {
        logic [31:0] data;
        logic        reg_we;
        logic [5:0]  rd;
        logic        jmp;
        logic [31:0] jdst;
    } bundle_t;

    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 32'd1);

    state_e      state_q, state_d;
    bundle_t     bnd_q, bnd_d, cur, src;
    logic [15:0] tcnt_q, tcnt_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rf_we_q, rf_we_d;
    logic [5:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        commit_q, commit_d;
    logic [31:0] retired_q, retired_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;
    logic        fin;

    always_comb begin
        cur.data   = ex.data;
        cur.reg_we = ex.reg_write_enabled;
        cur.rd     = ex.reg_write_dest;
        cur.jmp    = ex.is_jump_enabled;
        cur.jdst   = ex.jump_dest;
    end

    always_comb begin
        state_d          = state_q;
        bnd_d            = bnd_q;
        tcnt_d           = tcnt_q;
        mem_req_d        = mem_req_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        rf_we_d          = 1'b0;
        rf_waddr_d       = rf_waddr_q;
        rf_wdata_d       = rf_wdata_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        commit_d         = 1'b0;
        retired_d        = retired_q;
        misalign_d       = misalign_q;
        timeout_d        = timeout_q;
        fin              = 1'b0;
        src              = bnd_q;

        case (state_q)
            IDLE: begin
                if (ex.exec_valid) begin
                    bnd_d = cur;
                    if (ex.mem_write_enabled && ex.mem_write_dest[1:0] == 2'b00) begin
                        state_d     = MEM_WAIT;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {ex.mem_write_dest[31:2], 2'b00};
                        mem_wdata_d = ex.data;
                        tcnt_d      = '0;
                    end else begin
                        // misaligned stores are dropped but the bundle still retires
                        if (ex.mem_write_enabled) misalign_d = 1'b1;
                        fin = 1'b1;
                        src = cur;
                    end
                end
            end
            MEM_WAIT: begin
                if (dm.mem_ack) begin
                    mem_req_d = 1'b0;
                    fin       = 1'b1;
                end else if (tcnt_q == TMO_LAST) begin
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                    fin       = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // strobes are registered, so they are high during the COMMIT state
        if (fin) begin
            state_d   = COMMIT;
            commit_d  = 1'b1;
            retired_d = retired_q + 32'd1;
            if (src.reg_we && src.rd != 6'd0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = src.rd;
                rf_wdata_d = src.data;
            end
            if (src.jmp) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = src.jdst;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            bnd_q            <= '0;
            tcnt_q           <= '0;
            mem_req_q        <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            rf_we_q          <= 1'b0;
            rf_waddr_q       <= '0;
            rf_wdata_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            commit_q         <= 1'b0;
            retired_q        <= '0;
            misalign_q       <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            bnd_q            <= bnd_d;
            tcnt_q           <= tcnt_d;
            mem_req_q        <= mem_req_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            rf_we_q          <= rf_we_d;
            rf_waddr_q       <= rf_waddr_d;
            rf_wdata_q       <= rf_wdata_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            commit_q         <= commit_d;
            retired_q        <= retired_d;
            misalign_q       <= misalign_d;
            timeout_q        <= timeout_d;
        end
    end

    assign ex.exec_ready  = (state_q == IDLE);
    assign dm.mem_req     = mem_req_q;
    assign dm.mem_addr    = mem_addr_q;
    assign dm.mem_wdata   = mem_wdata_q;
    assign rf_we          = rf_we_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign commit         = commit_q;
    assign retired_count  = retired_q;
    assign misalign_err   = misalign_q;
    assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_mem_commit.sv
// Scoreboard bench for mem_commit: each bundle pushes its expected retire
// record; a monitor pops and compares on every commit strobe.
module tb_mem_commit;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rf_we, redirect_valid, commit, misalign_err, timeout_err;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata, redirect_pc, retired_count;

    mem_commit_if      ex_if ();
    mem_commit_dmem_if dm_if ();

    mem_commit #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn), .ex(ex_if), .dm(dm_if),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .commit(commit), .retired_count(retired_count),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic        redir;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h @%0t", tag, obs, expv, $time);
        end
    endtask

    // monitor: compare each retire against the scoreboard head
    always @(posedge clk) begin
        #1;
        if (rstn) begin
            if (commit) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
                    if (e.we) begin
                        chk("rf_waddr", {26'd0, rf_waddr}, {26'd0, e.waddr});
                        chk("rf_wdata", rf_wdata, e.wdata);
                    end
                    chk("redir", {31'd0, redirect_valid}, {31'd0, e.redir});
                    if (e.redir) chk("redir_pc", redirect_pc, e.pc);
                    chk("retired", retired_count, e.cnt);
                end
            end else begin
                chk("strobe_nocommit", {30'd0, rf_we, redirect_valid}, 32'd0);
            end
        end
    end

    task automatic idle_bus();
        ex_if.exec_valid        = 1'b0;
        ex_if.data              = '0;
        ex_if.mem_write_enabled = 1'b0;
        ex_if.mem_write_dest    = '0;
        ex_if.reg_write_enabled = 1'b0;
        ex_if.reg_write_dest    = '0;
        ex_if.is_jump_enabled   = 1'b0;
        ex_if.jump_dest         = '0;
    endtask

    // returns one time unit after the capture edge
    task automatic send(input logic [31:0] d, input logic mwe, input logic [31:0] maddr,
                        input logic rwe, input logic [5:0] rd, input logic jmp,
                        input logic [31:0] jdst);
        int   w;
        exp_t e;
        w = 0;
        while (!ex_if.exec_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 100) chk("ready_timeout", 32'd0, 32'd1);
        ex_if.exec_valid        = 1'b1;
        ex_if.data              = d;
        ex_if.mem_write_enabled = mwe;
        ex_if.mem_write_dest    = maddr;
        ex_if.reg_write_enabled = rwe;
        ex_if.reg_write_dest    = rd;
        ex_if.is_jump_enabled   = jmp;
        ex_if.jump_dest         = jdst;
        exp_cnt = exp_cnt + 1;
        e.we    = rwe && (rd != 6'd0);
        e.waddr = rd;
        e.wdata = d;
        e.redir = jmp;
        e.pc    = jdst;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_bus();
        dm_if.mem_ack = 1'b0;
        #23 rstn = 1'b1;
        step();
        chk("rst_ready", {31'd0, ex_if.exec_ready}, 32'd1);
        chk("rst_req", {31'd0, dm_if.mem_req}, 32'd0);
        chk("rst_commit", {31'd0, commit}, 32'd0);
        chk("rst_count", retired_count, 32'd0);
        chk("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);

        // 1: addi-like, with a stray mem_ack that must be ignored
        dm_if.mem_ack = 1'b1;
        send(32'h10, 1'b0, 32'h0, 1'b1, 6'd5, 1'b0, 32'h0);
        dm_if.mem_ack = 1'b0;
        chk("t1_commit", {31'd0, commit}, 32'd1);
        chk("t1_no_req", {31'd0, dm_if.mem_req}, 32'd0);
        chk("t1_busy", {31'd0, ex_if.exec_ready}, 32'd0);

        // 2: write to x0 suppressed; jump with link
        send(32'h55, 1'b0, 32'h0, 1'b1, 6'd0, 1'b0, 32'h0);
        chk("t2_commit", {31'd0, commit}, 32'd1);
        chk("t2_x0", {31'd0, rf_we}, 32'd0);
        chk("t2_hold_addr", {26'd0, rf_waddr}, 32'd5);
        send(32'h24, 1'b0, 32'h0, 1'b1, 6'd1, 1'b1, 32'h100);
        chk("t2_both", {30'd0, rf_we, redirect_valid}, 32'd3);

        // 3: aligned store + reg write, ack in third request cycle
        send(32'hDEADBEEF, 1'b1, 32'h40, 1'b1, 6'd7, 1'b0, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            chk("t3_req", {31'd0, dm_if.mem_req}, 32'd1);
            chk("t3_addr", dm_if.mem_addr, 32'h40);
            chk("t3_wdata", dm_if.mem_wdata, 32'hDEADBEEF);
            chk("t3_busy", {31'd0, ex_if.exec_ready}, 32'd0);
            // bundle offered while busy must not be captured
            ex_if.exec_valid     = (c == 1);
            ex_if.data           = 32'h12345678;
            ex_if.reg_write_enabled = 1'b1;
            ex_if.reg_write_dest = 6'd9;
            dm_if.mem_ack        = (c == 3);
            step();
            if (c == 1) idle_bus();
        end
        dm_if.mem_ack = 1'b0;
        chk("t3_req_drop", {31'd0, dm_if.mem_req}, 32'd0);
        chk("t3_commit", {31'd0, commit}, 32'd1);
        chk("t3_pc_hold", redirect_pc, 32'h100);
        step();
        chk("t3_ready", {31'd0, ex_if.exec_ready}, 32'd1);

        // 4: misaligned store
        send(32'hCAFE, 1'b1, 32'h41, 1'b0, 6'd0, 1'b0, 32'h0);
        chk("t4_misalign", {31'd0, misalign_err}, 32'd1);
        chk("t4_no_req", {31'd0, dm_if.mem_req}, 32'd0);
        chk("t4_commit", {31'd0, commit}, 32'd1);
        send(32'h1, 1'b0, 32'h0, 1'b1, 6'd3, 1'b0, 32'h0);
        chk("t4_sticky", {31'd0, misalign_err}, 32'd1);

        // 5: store timeout with ACK_TIMEOUT=4
        send(32'hA5A5A5A5, 1'b1, 32'h80, 1'b0, 6'd0, 1'b0, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            chk("t5_req", {31'd0, dm_if.mem_req}, 32'd1);
            chk("t5_no_tmo", {31'd0, timeout_err}, 32'd0);
            step();
        end
        chk("t5_req_drop", {31'd0, dm_if.mem_req}, 32'd0);
        chk("t5_tmo", {31'd0, timeout_err}, 32'd1);
        chk("t5_commit", {31'd0, commit}, 32'd1);

        // random non-store traffic
        for (int i = 0; i < 8; i++) begin
            send($urandom, 1'b0, 32'h0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
        end
        step();
        chk("sb_drained", exp_q.size(), 32'd0);

        // reset while a store is waiting for its ack
        send(32'h77, 1'b1, 32'hC0, 1'b0, 6'd0, 1'b0, 32'h0);
        chk("t6_req", {31'd0, dm_if.mem_req}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_req_rst", {31'd0, dm_if.mem_req}, 32'd0);
        chk("t6_count_rst", retired_count, 32'd0);
        chk("t6_errs_rst", {30'd0, misalign_err, timeout_err}, 32'd0);
        exp_q.delete();
        exp_cnt = 0;
        #4 rstn = 1'b1;
        step();
        send(32'h99, 1'b0, 32'h0, 1'b1, 6'd2, 1'b0, 32'h0);
        chk("t6_count", retired_count, 32'd1);
        step();
        chk("sb_final", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
